// File: rtl/mul_booth_pp_gen.sv
// Radix-4 Booth partial-product generator: 33 unshifted 128-bit two's-complement terms per 64x64 multiply.
// Optional MUL_BOOTH_PIPE_EN adds a stage registering Booth selects and X (latency 2 instead of 1).
module mul_booth_pp_gen #(
  parameter int XLEN = 64,
  localparam int PP_NUM = XLEN/2 + 1,
  localparam int PP_W = 2*XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [1:0]      i_mul_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [PP_W-1:0] o_part_result [PP_NUM-1:0],
  output logic [1:0]      o_out_op
);

  localparam int XW = XLEN + 2;

  // select encoding: [0] = +/-X, [1] = +/-2X, [2] = negate
  function automatic logic [2:0] booth_enc(input logic [2:0] g);
    case (g)
      3'b001, 3'b010: booth_enc = 3'b001;
      3'b011:         booth_enc = 3'b010;
      3'b100:         booth_enc = 3'b110;
      3'b101, 3'b110: booth_enc = 3'b101;
      default:        booth_enc = 3'b000;
    endcase
  endfunction

  function automatic logic [PP_W-1:0] booth_pp(input logic [2:0] sel, input logic [XW-1:0] x);
    logic [PP_W-1:0] xs;
    logic [PP_W-1:0] v;
    xs = {{(PP_W-XW){x[XW-1]}}, x};
    v = sel[0] ? xs : (sel[1] ? (xs << 1) : '0);
    booth_pp = sel[2] ? (~v + PP_W'(1)) : v;
  endfunction

  logic            w_s1_signed;
  logic            w_s2_signed;
  logic [XW-1:0]   w_x;
  logic [XW-1:0]   w_y;
  logic [XW:0]     w_yy;
  logic [2:0]      w_sel [PP_NUM-1:0];

  assign w_s1_signed = (i_mul_op != 2'b11);
  assign w_s2_signed = ~i_mul_op[1];
  assign w_x  = {{2{w_s1_signed & i_src1[XLEN-1]}}, i_src1};
  assign w_y  = {{2{w_s2_signed & i_src2[XLEN-1]}}, i_src2};
  assign w_yy = {w_y, 1'b0};

  always_comb begin
    for (int i = 0; i < PP_NUM; i++) begin
      w_sel[i] = booth_enc(w_yy[2*i +: 3]);
    end
  end

  logic            r_out_valid;
  logic [1:0]      r_out_op;
  logic [PP_W-1:0] r_part_result [PP_NUM-1:0];

  logic [2:0]      w_pp_sel [PP_NUM-1:0];
  logic [XW-1:0]   w_pp_x;
  logic [1:0]      w_pp_op;
  logic            w_out_en;
  logic            w_next_valid;

`ifdef MUL_BOOTH_PIPE_EN
  logic            r_s1_valid;
  logic [2:0]      r_s1_sel [PP_NUM-1:0];
  logic [XW-1:0]   r_s1_x;
  logic [1:0]      r_s1_op;
  logic            w_s1_adv;

  assign w_s1_adv   = !r_out_valid || i_out_ready;
  assign o_in_ready = !r_s1_valid || w_s1_adv;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_op    <= '0;
      for (int i = 0; i < PP_NUM; i++) r_s1_sel[i] <= '0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
    end else if (o_in_ready) begin
      r_s1_valid <= i_in_valid;
      if (i_in_valid) begin
        r_s1_x   <= w_x;
        r_s1_op  <= i_mul_op;
        r_s1_sel <= w_sel;
      end
    end
  end

  assign w_pp_sel     = r_s1_sel;
  assign w_pp_x       = r_s1_x;
  assign w_pp_op      = r_s1_op;
  assign w_out_en     = w_s1_adv;
  assign w_next_valid = r_s1_valid;
`else
  assign o_in_ready   = !r_out_valid || i_out_ready;
  assign w_pp_sel     = w_sel;
  assign w_pp_x       = w_x;
  assign w_pp_op      = i_mul_op;
  assign w_out_en     = o_in_ready;
  assign w_next_valid = i_in_valid;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      for (int i = 0; i < PP_NUM; i++) r_part_result[i] <= '0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_out_en) begin
      r_out_valid <= w_next_valid;
      if (w_next_valid) begin
        r_out_op <= w_pp_op;
        for (int i = 0; i < PP_NUM; i++) r_part_result[i] <= booth_pp(w_pp_sel[i], w_pp_x);
      end
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_op      = r_out_op;
  assign o_part_result = r_part_result;

endmodule

// File: tb/tb_mul_booth_pp_gen.sv
// Self-checking bench for mul_booth_pp_gen: vector table, directed handshake/flush sequences, random vs product model.
module tb_mul_booth_pp_gen;

`ifdef MUL_BOOTH_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NRAND = 10000;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [1:0]   mul_op;
  logic [63:0]  src1, src2;
  logic         in_ready, out_valid;
  logic [127:0] pp [32:0];
  logic [1:0]   out_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_booth_pp_gen dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_mul_op(mul_op), .i_src1(src1), .i_src2(src2), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_part_result(pp), .o_out_op(out_op)
  );

  typedef struct {
    logic [1:0]   op;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] prod;
  } vec_t;

  typedef struct {
    logic [1:0]   op;
    logic [127:0] prod;
  } exp_t;

  vec_t tbl [8];
  exp_t q [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pp_sum();
    logic [127:0] s;
    s = '0;
    for (int i = 0; i < 33; i++) s = s + (pp[i] << (2*i));
    return s;
  endfunction

  // reference: extend per operand signedness, multiply, keep 128 bits
  function automatic logic [127:0] ref_prod(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb;
    ea = (op != 2'b11) ? {{64{a[63]}}, a} : {64'b0, a};
    eb = (op[1] == 1'b0) ? {{64{b[63]}}, b} : {64'b0, b};
    return ea * eb;
  endfunction

  // one clock: accepted items are withdrawn from in_valid after the edge
  task automatic cyc();
    logic acc;
    #1;
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc) in_valid = 1'b0;
  endtask

  task automatic drive(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    mul_op = op; src1 = a; src2 = b; in_valid = 1'b1;
  endtask

  initial begin
    logic [127:0] pa, pb;
    logic [1:0]   opb;
    int n, nz, sent, ncyc;
    logic acc, xfer;
    exp_t e;

    tbl[0] = '{2'b00, 64'd3, 64'd5, 128'd15};
    tbl[1] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1};
    tbl[2] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF};
    tbl[3] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001};
    tbl[4] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    tbl[5] = '{2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 128'h4000_0000_0000_0000_0000_0000_0000_0000};
    tbl[6] = '{2'b01, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 128'hC000_0000_0000_0000_8000_0000_0000_0000};
    tbl[7] = '{2'b10, 64'd0, 64'hDEAD_BEEF_1234_5678, 128'd0};

    // reset held two cycles with an item presented
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(2'b00, 64'd3, 64'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    nz = 0;
    for (int i = 0; i < 33; i++) if (pp[i] !== '0) nz++;
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_out_op", 128'(out_op), 128'd0);
    chk("reset_pp_nonzero_count", 128'(nz), 128'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'd1);

    // MUL 3*5: individual partial products and latency
    drive(2'b00, 64'd3, 64'd5);
    cyc();
    n = 1;
    while (!out_valid && n < 10) begin cyc(); n++; end
    chk("mul35_latency", 128'(n), 128'(LAT));
    chk("mul35_pp0", pp[0], 128'd3);
    chk("mul35_pp1", pp[1], 128'd3);
    nz = 0;
    for (int i = 2; i < 33; i++) if (pp[i] !== '0) nz++;
    chk("mul35_pp_rest", 128'(nz), 128'd0);
    chk("mul35_sum", pp_sum(), 128'd15);
    chk("mul35_op", 128'(out_op), 128'd0);
    cyc();

    // MULH -1*-1 and MULHU all-ones*1 at the partial-product level
    drive(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc();
    for (int k = 1; k < LAT; k++) cyc();
    chk("mulh_m1_pp0", pp[0], 128'd1);
    nz = 0;
    for (int i = 1; i < 33; i++) if (pp[i] !== '0) nz++;
    chk("mulh_m1_pp_rest", 128'(nz), 128'd0);
    cyc();
    drive(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    cyc();
    for (int k = 1; k < LAT; k++) cyc();
    chk("mulhu_pp0_zext", pp[0], 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
    nz = 0;
    for (int i = 1; i < 33; i++) if (pp[i] !== '0) nz++;
    chk("mulhu_pp_rest", 128'(nz), 128'd0);
    cyc();

    // vector table
    for (int t = 0; t < 8; t++) begin
      drive(tbl[t].op, tbl[t].a, tbl[t].b);
      cyc();
      n = 1;
      while (!out_valid && n < 10) begin cyc(); n++; end
      chk($sformatf("tbl%0d_valid", t), 128'(out_valid), 128'd1);
      chk($sformatf("tbl%0d_sum", t), pp_sum(), tbl[t].prod);
      chk($sformatf("tbl%0d_op", t), 128'(out_op), 128'(tbl[t].op));
      cyc();
    end

    // backpressure: A held on output, B waits, then drain and accept together
    pa = ref_prod(2'b00, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFF9);
    opb = 2'b10;
    pb = ref_prod(opb, 64'h8765_4321_0FED_CBA9, 64'hF0F0_F0F0_0F0F_0F0F);
    out_ready = 1'b0;
    drive(2'b00, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFF9);
    cyc();
    drive(opb, 64'h8765_4321_0FED_CBA9, 64'hF0F0_F0F0_0F0F_0F0F);
    for (int k = 1; k < LAT; k++) cyc();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", 128'(out_valid), 128'd1);
      chk("bp_hold_sum", pp_sum(), pa);
      chk("bp_hold_in_ready", 128'(in_ready), 128'd0);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    cyc();
    chk("bp_b_valid", 128'(out_valid), 128'd1);
    chk("bp_b_sum", pp_sum(), pb);
    chk("bp_b_op", 128'(out_op), 128'(opb));
    in_valid = 1'b0;
    cyc();
    chk("bp_no_dup", 128'(out_valid), 128'd0);

    // flush while A is on the output and B is presented
    out_ready = 1'b0;
    drive(2'b01, 64'd77, 64'd99);
    cyc();
    for (int k = 1; k < LAT; k++) cyc();
    chk("flush_a_present", 128'(out_valid), 128'd1);
    drive(2'b11, 64'd11, 64'd13);
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_next_valid", 128'(out_valid), 128'd0);
    out_ready = 1'b1;
    nz = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (out_valid) nz++;
    end
    chk("flush_nothing_delivered", 128'(nz), 128'd0);

    // random stream with random backpressure, checked in order against the product model
    sent = 0; ncyc = 0;
    while ((sent < NRAND || q.size() > 0) && ncyc < 60000) begin
      if (sent < NRAND) begin
        in_valid = ($urandom_range(3) != 0);
        mul_op = 2'($urandom_range(3));
        case ($urandom_range(7))
          0: src1 = '1;
          1: src1 = 64'h8000_0000_0000_0000;
          2: src1 = '0;
          default: src1 = {$urandom, $urandom};
        endcase
        case ($urandom_range(7))
          0: src2 = '1;
          1: src2 = 64'h7FFF_FFFF_FFFF_FFFF;
          2: src2 = 64'h8000_0000_0000_0000;
          default: src2 = {$urandom, $urandom};
        endcase
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      acc = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_output", 128'd1, 128'd0);
        end else begin
          e = q.pop_front();
          chk("rand_sum", pp_sum(), e.prod);
          chk("rand_op", 128'(out_op), 128'(e.op));
        end
      end
      if (acc) begin
        q.push_back('{mul_op, ref_prod(mul_op, src1, src2)});
        sent++;
      end
      @(posedge clk); #1;
      ncyc++;
    end
    in_valid = 1'b0;
    chk("rand_all_sent", 128'(sent), 128'(NRAND));
    chk("rand_queue_drained", 128'(q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_booth_pp_gen.md
Name: mul_booth_pp_gen

Overview:
- Radix-4 Booth partial-product generator for the 64x64 multiplier; sits directly upstream of the Wallace-tree compressor.
- Accepts operands and a multiply op via valid/ready.
- Produces 33 registered, unshifted 128-bit two's-complement partial products. The compressor applies the 2*i shift itself and sums the products with no extra carry-in.
- Passes the op downstream so the result stage can pick the low or high 64 bits.

Parameters:
- XLEN, 64, operand width. Derived values: PP_NUM = XLEN/2+1 = 33; PP_W = 2*XLEN = 128.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill all in-flight work (pipeline redirect)
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands this cycle
- mul_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- src1  in  XLEN  multiplicand
- src2  in  XLEN  multiplier (Booth-recoded)
- out_valid  out  1  part_result valid
- out_ready  in  1  compressor stage accepts
- part_result  out  PP_W x PP_NUM (unpacked [32:0])  partial products, unshifted
- out_op  out  2  registered mul_op of the item on the output

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: out_valid=0, out_op=0, all part_result entries 0, internal valid flags 0. A reset mid-operation discards the item.
- Signedness:
  - src1 is signed for MUL, MULH and MULHSU; unsigned for MULHU.
  - src2 is signed for MUL and MULH; unsigned for MULHSU and MULHU.
- Extension:
  - X = src1 extended to 66 bits per its signedness.
  - Y = src2 extended to 66 bits per its signedness.
  - y[-1] = 0.
- Group i (0..32) = {y[2i+1], y[2i], y[2i-1]}. Selection:
  - 000, 111 -> 0
  - 001, 010 -> +X
  - 011 -> +2X
  - 100 -> -2X
  - 101, 110 -> -X
- Width and negation:
  - Each selected value is sign-extended to 128 bits before use.
  - Negation is full 128-bit two's complement (~v+1). No separate negate bit is emitted.
  - The invariant sum over i of (part_result[i] << 2i), mod 2^128, equals the full 128-bit product for the op's signedness.
- Handshake:
  - Accept when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready, so a full output register accepts a new item in the same cycle it drains.
  - No combinational path from in_valid to out_valid.
- Latency: 1 cycle from accept to out_valid (base build).
- Backpressure: while out_valid && !out_ready, part_result and out_op hold stable and in_ready=0.
- Flush:
  - Synchronous, highest priority after rst.
  - Next cycle out_valid=0 and all internal valid flags are 0.
  - An item presented with in_valid in the flush cycle is dropped.
  - part_result data need not be cleared.
- Simultaneous drain and accept: the new item overwrites the output register; no bubble.

Optional Feature:
- MUL_BOOTH_PIPE_EN defined:
  - Adds an internal stage that registers the Booth-encoded group selects and X.
  - Partial-product muxing/negation is done in the second stage. Latency becomes 2 cycles.
  - in_ready = !stage1_valid || stage1 advances, where stage1 advances when the output register is empty or draining (full throughput, 1 item/cycle).
  - Flush clears both stages.
- Undefined: single stage, latency 1, as described above.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_op=0, all part_result=0; in_ready=1 after rst drops.
- MUL src1=3, src2=5 -> next cycle:
  - part_result[0]=3, part_result[1]=3, others 0.
  - Shifted sum = 15; out_op=00.
- Sign and unsigned edge cases:
  - MULH src1=-1, src2=-1 -> part_result[0]=1, others 0; product 1.
  - MULHU src1=0xFFFF_FFFF_FFFF_FFFF, src2=1 -> part_result[0]=0x0000...0000_FFFF_FFFF_FFFF_FFFF (zero-extended), others 0.
- Backpressure: push A, hold out_ready=0 for 5 cycles with B presented:
  - A stable, in_ready=0.
  - Release: A transfers, B is accepted that same cycle and appears the next cycle.
  - No loss or duplication.
- Flush: accept A, assert flush with B on in_valid in the cycle A is on the output -> out_valid=0 next cycle; neither A nor B is ever delivered.
- Random: 10k random src1/src2/mul_op with random out_ready -> the shifted sum over part_result[i]<<2i matches the 128-bit reference product per op signedness; order preserved. Run with and without MUL_BOOTH_PIPE_EN.
